// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared states and glyph geometry for the LED matrix scroller
package led_matrix_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam int GLYPH_W = 8;
  localparam int ROWS = 8;
  localparam logic [7:0] BLANK = 8'hFF;
endpackage

// File: rtl/led_matrix_scroller_decoder.sv
// decoder8x8: combinational glyph lookup, bit 8*r+c = row r, column c
module decoder8x8
  import led_matrix_pkg::*;
(
  input  logic [7:0]  code,
  output logic [63:0] glyph
);
  always_comb begin
    glyph = code == BLANK ? 64'h0 :
            code == 8'd0  ? 64'h003C424242423C00 :
            code == 8'd1  ? 64'h0038101010181000 :
            code == 8'd2  ? 64'h00FF81818181FF00 :
            code == 8'd3  ? 64'h0018244242241800 : 64'h0;
  end
endmodule

// File: rtl/led_matrix_scroller.sv
// led_matrix_scroller: scrolls buffered glyph codes right-to-left across an 8x8 frame
module led_matrix_scroller
  import led_matrix_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int STEP_DIV = 2500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic [$clog2(DEPTH+1)-1:0] msg_len,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic                       loop,
  output logic [63:0]                array,
  output logic                       busy,
  output logic                       done,
  output logic                       wrap
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STEP_DIV);
  logic [7:0] msg_buf [DEPTH];
  state_t state, state_n;
  logic [LW-1:0] len, len_n;
  logic [AW-1:0] char_idx, char_n;
  logic [2:0] col_idx, col_n, flush_cnt, flush_n;
  logic [SW-1:0] step_cnt, step_n;
  logic [63:0] glyph, shifted, array_n;
  logic loop_r, loop_n, done_n, wrap_n, tick, last_char;
  decoder8x8 u_dec (.code(msg_buf[char_idx]), .glyph(glyph));
  always_ff @(posedge clk) if (wr_en) msg_buf[wr_addr] <= wr_data;
  assign busy = state != IDLE;
  always_comb begin
    tick = step_cnt == SW'(STEP_DIV - 1) && !pause;
    last_char = LW'(char_idx) + LW'(1) == len;
    for (int r = 0; r < ROWS; r++) begin
      shifted[GLYPH_W*r +: GLYPH_W-1] = array[GLYPH_W*r+1 +: GLYPH_W-1];
      shifted[GLYPH_W*r+GLYPH_W-1] = state == RUN && glyph[{r[2:0], col_idx}];
    end
    state_n = state;
    len_n = len;
    loop_n = loop_r;
    char_n = char_idx;
    col_n = col_idx;
    flush_n = flush_cnt;
    step_n = step_cnt;
    array_n = array;
    done_n = 1'b0;
    wrap_n = 1'b0;
    if (state == IDLE) begin
      array_n = '0;
      step_n = '0;
      if (start && msg_len != '0) begin
        state_n = RUN;
        len_n = msg_len > LW'(DEPTH) ? LW'(DEPTH) : msg_len;
        loop_n = loop;
        char_n = '0;
        col_n = '0;
      end
    end else if (stop) begin
      state_n = IDLE;
      array_n = '0;
      step_n = '0;
    end else if (!pause) begin
      step_n = tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        array_n = shifted;
        if (state == RUN) begin
          col_n = col_idx + 3'd1;
          if (col_idx == 3'd7) begin
            char_n = last_char ? '0 : char_idx + 1'b1;
            wrap_n = last_char && loop_r;
            if (last_char && !loop_r) begin
              state_n = FLUSH;
              flush_n = '0;
            end
          end
        end else begin
          flush_n = flush_cnt + 3'd1;
          if (flush_cnt == 3'd7) begin
            state_n = IDLE;
            done_n = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      len <= '0;
      loop_r <= 1'b0;
      char_idx <= '0;
      col_idx <= '0;
      flush_cnt <= '0;
      step_cnt <= '0;
      array <= '0;
      done <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      loop_r <= loop_n;
      char_idx <= char_n;
      col_idx <= col_n;
      flush_cnt <= flush_n;
      step_cnt <= step_n;
      array <= array_n;
      done <= done_n;
      wrap <= wrap_n;
    end
  end
endmodule

// File: tb/tb_led_matrix_scroller.sv
// tb_led_matrix_scroller: directed stimulus with a cycle-stamped scoreboard and decoupled monitor
module tb_led_matrix_scroller;
  localparam logic [63:0] G0 = 64'h003C424242423C00;
  localparam logic [63:0] G1 = 64'h0038101010181000;
  localparam logic [63:0] G2 = 64'h00FF81818181FF00;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] msg_len = '0;
  logic [63:0] array;
  logic busy, done, wrap;
  int cyc = 0, checks = 0, errors = 0, n_done = 0, n_wrap = 0, a = 0, mc;
  string mn;
  logic [66:0] mv;
  int q_cyc[$];
  string q_name[$];
  logic [66:0] q_val[$];

  led_matrix_scroller #(.DEPTH(4), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .array(array), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (wrap === 1'b1) n_wrap++;
    while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
      mc = q_cyc.pop_front();
      mn = q_name.pop_front();
      mv = q_val.pop_front();
      checks++;
      if (mc != cyc || {array, busy, done, wrap} !== mv) begin
        errors++;
        $display("FAIL %s cyc=%0d (due %0d): got array=%h busy=%b done=%b wrap=%b, want array=%h busy=%b done=%b wrap=%b",
                 mn, cyc, mc, array, busy, done, wrap, mv[66:3], mv[2], mv[1], mv[0]);
      end
    end
  end

  task automatic exp(input int c, input string n, input logic [63:0] arr, input logic b, input logic d, input logic w);
    q_cyc.push_back(c);
    q_name.push_back(n);
    q_val.push_back({arr, b, d, w});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] ad, input logic [7:0] d);
    wr_addr = ad;
    wr_data = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [2:0] len, input logic lp, output int acc);
    msg_len = len;
    loop = lp;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    exp(2, "reset", 64'h0, 0, 0, 0);
    wait_to(3);
    rst = 1'b1;
    exp(4, "post_reset", 64'h0, 0, 0, 0);
    wait_to(5);
    // zero-length start must be ignored
    msg_len = 3'd0;
    start = 1'b1;
    wait_to(8);
    start = 1'b0;
    exp(8, "len0_idle", 64'h0, 0, 0, 0);
    wait_to(9);
    // single glyph, no loop: fill, flush, done
    wr(2'd0, 8'd1);
    go(3'd1, 1'b0, a);
    exp(a, "s1_accept", 64'h0, 1, 0, 0);
    exp(a + 3, "s1_pre_tick", 64'h0, 1, 0, 0);
    exp(a + 4, "s1_tick1", 64'h0, 1, 0, 0);
    exp(a + 20, "s1_tick5", 64'h00C0808080C08000, 1, 0, 0);
    exp(a + 32, "s1_tick8", G1, 1, 0, 0);
    exp(a + 48, "s1_flush4", 64'h0003010101010100, 1, 0, 0);
    exp(a + 63, "s1_flush7", 64'h0, 1, 0, 0);
    exp(a + 64, "s1_done", 64'h0, 0, 1, 0);
    exp(a + 65, "s1_after", 64'h0, 0, 0, 0);
    wait_to(a + 66);
    // two chars looping, then stop coincident with a tick
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd1);
    go(3'd2, 1'b1, a);
    exp(a + 63, "loop_tick15", 64'h0070202020302000, 1, 0, 0);
    exp(a + 64, "loop_wrap1", G1, 1, 0, 1);
    exp(a + 65, "loop_after1", G1, 1, 0, 0);
    exp(a + 128, "loop_wrap2", G1, 1, 0, 1);
    exp(a + 131, "loop_pre_stop", G1, 1, 0, 0);
    wait_to(a + 131);
    stop = 1'b1;
    wait_to(a + 132);
    stop = 1'b0;
    exp(a + 132, "stop_tick", 64'h0, 0, 0, 0);
    exp(a + 134, "stop_idle", 64'h0, 0, 0, 0);
    wait_to(a + 135);
    // restart from char 0, rewrite char 1 mid-render
    go(3'd2, 1'b0, a);
    exp(a + 32, "restart_char0", G0, 1, 0, 0);
    exp(a + 64, "rewrite_mix", 64'h00F880808088F000, 1, 0, 0);
    exp(a + 96, "rewrite_done", 64'h0, 0, 1, 0);
    wait_to(a + 49);
    wr(2'd1, 8'd2);
    wait_to(a + 97);
    // pause for 20 cycles after tick 4, then stop while paused
    wr(2'd0, 8'd1);
    go(3'd1, 1'b0, a);
    exp(a + 16, "pause_tick4", 64'h0080000000800000, 1, 0, 0);
    exp(a + 20, "pause_frozen", 64'h0080000000800000, 1, 0, 0);
    exp(a + 37, "pause_end", 64'h0080000000800000, 1, 0, 0);
    exp(a + 39, "pause_resume", 64'h0080000000800000, 1, 0, 0);
    exp(a + 40, "pause_tick5", 64'h00C0808080C08000, 1, 0, 0);
    exp(a + 43, "pause2_hold", 64'h00C0808080C08000, 1, 0, 0);
    wait_to(a + 17);
    pause = 1'b1;
    wait_to(a + 37);
    pause = 1'b0;
    wait_to(a + 41);
    pause = 1'b1;
    wait_to(a + 43);
    stop = 1'b1;
    wait_to(a + 44);
    stop = 1'b0;
    pause = 1'b0;
    exp(a + 44, "stop_paused", 64'h0, 0, 0, 0);
    wait_to(a + 46);
    // msg_len beyond DEPTH clamps to 4 characters; char 0 is blank
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'd0);
    wr(2'd2, 8'd1);
    wr(2'd3, 8'd2);
    go(3'd5, 1'b0, a);
    exp(a + 32, "clamp_blank", 64'h0, 1, 0, 0);
    exp(a + 64, "clamp_c1", G0, 1, 0, 0);
    exp(a + 96, "clamp_c2", G1, 1, 0, 0);
    exp(a + 128, "clamp_c3", G2, 1, 0, 0);
    exp(a + 159, "clamp_flush7", 64'h0001010101010100, 1, 0, 0);
    exp(a + 160, "clamp_done", 64'h0, 0, 1, 0);
    exp(a + 161, "clamp_after", 64'h0, 0, 0, 0);
    wait_to(a + 163);
    checks++;
    if (n_done != 3) begin
      errors++;
      $display("FAIL done_count: got %0d, want 3", n_done);
    end
    checks++;
    if (n_wrap != 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d, want 2", n_wrap);
    end
    checks++;
    if (q_cyc.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q_cyc.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
